mips_dmem_responder: RTL and testbench

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_dmem_responder_if.sv | 27 ++
 rtl/mips_dmem_array.sv | 27 ++
 rtl/mips_dmem_responder.sv | 153 +++++++++++++++
 tb/tb_mips_dmem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory responder slice.
package mips_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned WAIT_CYCLES_MAX = 7;
  localparam int unsigned CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between the datapath initiator and the data-memory responder.
// The err signal exists only when DMEM_BOUNDS_CHECK_EN is defined.
interface mips_dmem_responder_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
`else
  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
`endif

endinterface

// File: rtl/mips_dmem_array.sv
// Single-port synchronous RAM; read data register only updates on read accesses.
module mips_dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Wait-state data-memory responder: IDLE -> WAIT -> RESP, one-cycle ack per access.
// DMEM_BOUNDS_CHECK_EN adds an err output and blocks accesses with addr >= DEPTH.
module mips_dmem_responder
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_dmem_responder_if.slave  bus
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              rd_gate_q;

  logic              acc_we;
  logic [DATA_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              commit;
  logic              addr_hi_nz;
  logic              oob;
  logic              mem_en;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the request edge, so use the live bus fields
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_we    = bus.we;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end
  end

  assign commit = (state_d == RESP) && (state_q != RESP);

  generate
    if (IDX_W < DATA_W) begin : g_hi
      assign addr_hi_nz = |acc_addr[DATA_W-1:IDX_W];
    end else begin : g_no_hi
      assign addr_hi_nz = 1'b0;
    end
  endgenerate

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = addr_hi_nz;
`else
  logic unused_addr_hi;
  assign oob            = 1'b0;
  assign unused_addr_hi = addr_hi_nz;
`endif

  // The RAM has no reset, so keep it quiet while reset is held
  assign mem_en = commit && !oob && reset;

  mips_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_we),
    .idx   (IDX_W'(acc_addr)),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_gate_q <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= commit;
      busy_q  <= (state_d != IDLE);
      if (commit && !acc_we) begin
        rd_gate_q <= !oob;
      end
      if ((state_q == IDLE) && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
`ifdef DMEM_BOUNDS_CHECK_EN
      err_q <= commit && oob;
`endif
    end
  end

  // rd_gate_q masks the unreset RAM register to zero after reset and after out-of-range reads
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rd_gate_q ? mem_rdata : '0;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign bus.err   = err_q;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 instance (a) and a WAIT_CYCLES=0 instance (b).
`timescale 1ns/1ps
module tb_mips_dmem_responder;

  localparam int unsigned DW = 16;
  localparam int          WA = 2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [DW-1:0] last_rd_a = '0;
  logic [DW-1:0] last_rd_b = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_dmem_responder_if #(.DATA_W(DW)) ifa ();
  mips_dmem_responder_if #(.DATA_W(DW)) ifb ();

  mips_dmem_responder #(.DATA_W(DW), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  mips_dmem_responder #(.DATA_W(DW), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every ack pops one expectation (latency stamp, rdata, err)
  always @(negedge clk) begin
    exp_t e;
    if (ifa.ack === 1'b1) begin
      if (qa.size() == 0) flag("a_unexpected_ack");
      else begin
        e = qa.pop_front();
        check("a_ack_cycle", 32'(cyc), 32'(e.cyc));
        check("a_rdata", 32'(ifa.rdata), 32'(e.rdata));
`ifdef DMEM_BOUNDS_CHECK_EN
        check("a_err", 32'(ifa.err), 32'(e.err));
`endif
      end
    end
    if (ifb.ack === 1'b1) begin
      if (qb.size() == 0) flag("b_unexpected_ack");
      else begin
        e = qb.pop_front();
        check("b_ack_cycle", 32'(cyc), 32'(e.cyc));
        check("b_rdata", 32'(ifb.rdata), 32'(e.rdata));
`ifdef DMEM_BOUNDS_CHECK_EN
        check("b_err", 32'(ifb.err), 32'(e.err));
`endif
      end
    end
  end

  task automatic wait_idle_a();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.busy === 1'b0) return;
    end
    flag("a_idle_timeout");
  endtask

  // One transaction on (a); ack is sampled high on the (WA+1)th edge after the request edge
  task automatic txa(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = d;
    e.cyc   = cyc + 1 + WA;
    e.rdata = w ? last_rd_a : exp_rd;
    e.err   = exp_err;
    if (!w) last_rd_a = exp_rd;
    qa.push_back(e);
    @(negedge clk);
    ifa.req = 1'b0;
    wait_idle_a();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   c0;
    logic w;
    logic [DW-1:0] a;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;

    // Reset state, before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_a_ack", 32'(ifa.ack), 32'd0);
    check("rst_a_busy", 32'(ifa.busy), 32'd0);
    check("rst_a_rdata", 32'(ifa.rdata), 32'd0);
    check("rst_b_busy", 32'(ifb.busy), 32'd0);
    check("rst_b_rdata", 32'(ifb.rdata), 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    check("rst_a_err", 32'(ifa.err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Write then read 0x0010 with two wait states
    txa(1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0);
    txa(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);

    // Reset pulse in the middle of a waited write to addr 5
    txa(1'b1, 16'h0005, 16'h1111, 16'h0000, 1'b0);
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 16'h0005; ifa.wdata = 16'hBEEF;
    @(negedge clk);
    ifa.req = 1'b0;
    check("abort_busy_in_wait", 32'(ifa.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy_async", 32'(ifa.busy), 32'd0);
    check("abort_ack_async", 32'(ifa.ack), 32'd0);
    check("abort_rdata_async", 32'(ifa.rdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rd_a = '0;
    last_rd_b = '0;
    repeat (4) @(negedge clk);
    txa(1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0);

    // Inputs changed while busy are ignored: response is for addr 7, no second transaction
    txa(1'b1, 16'h0007, 16'h7777, 16'h0000, 1'b0);
    txa(1'b1, 16'h0009, 16'h9999, 16'h0000, 1'b0);
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 16'h0007; ifa.wdata = 16'h0000;
    e.cyc = cyc + 1 + WA; e.rdata = 16'h7777; e.err = 1'b0;
    last_rd_a = 16'h7777;
    qa.push_back(e);
    @(negedge clk);
    ifa.we = 1'b1; ifa.addr = 16'h0009; ifa.wdata = 16'hDEAD;
    begin : wait_ack
      for (int i = 0; i < 10; i++) begin
        if (ifa.ack === 1'b1) disable wait_ack;
        @(negedge clk);
      end
      flag("busy_change_ack_timeout");
    end
    ifa.req = 1'b0;
    wait_idle_a();
    repeat (4) @(negedge clk);
    txa(1'b0, 16'h0009, 16'h0000, 16'h9999, 1'b0);

    // Top index of the array
    txa(1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0);
    txa(1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0);

    // Address beyond DEPTH
`ifdef DMEM_BOUNDS_CHECK_EN
    txa(1'b1, 16'h0105, 16'hAAAA, 16'h0000, 1'b1);
    txa(1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0);
    txa(1'b0, 16'h0105, 16'h0000, 16'h0000, 1'b1);
`else
    txa(1'b1, 16'h0105, 16'hAAAA, 16'h0000, 1'b0);
    txa(1'b0, 16'h0005, 16'h0000, 16'hAAAA, 1'b0);
`endif

    // Zero wait states, req held high: alternating write/read to addrs 0..3, ack every 2nd cycle
    @(negedge clk);
    c0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      w = ((i % 2) == 0);
      a = DW'(i / 2);
      ifb.req = 1'b1; ifb.we = w; ifb.addr = a; ifb.wdata = 16'hC0D0 + a;
      e.cyc   = c0 + 2 * i;
      e.rdata = w ? last_rd_b : (16'hC0D0 + a);
      e.err   = 1'b0;
      if (!w) last_rd_b = 16'hC0D0 + a;
      qb.push_back(e);
      @(negedge clk);
      @(negedge clk);
    end
    ifb.req = 1'b0;

    repeat (6) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
